// File: rtl/rv_core_sequencer_if.sv
// Sequencer-to-core bus: instruction fetch, register bank control and exec unit handshake.
// master = sequencer side, slave = memory / register_bank / exec_unit side.
interface rv_core_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [4:0]  rf_rd_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        exec_start;
    logic        exec_done;
    logic [31:0] exec_result;
    logic        exec_wb_en;
    logic        exec_branch_taken;
    logic [31:0] exec_branch_target;
    logic        exec_illegal;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  trap_cause;

    modport master (
        output imem_req, imem_addr, instr, pc,
        output rf_rs1_addr, rf_rs2_addr, rf_rd_addr, rf_we, rf_wdata,
        output exec_start, instret, halted, trap_cause,
        input  imem_ack, imem_rdata,
        input  exec_done, exec_result, exec_wb_en,
        input  exec_branch_taken, exec_branch_target, exec_illegal
    );

    modport slave (
        input  imem_req, imem_addr, instr, pc,
        input  rf_rs1_addr, rf_rs2_addr, rf_rd_addr, rf_we, rf_wdata,
        input  exec_start, instret, halted, trap_cause,
        output imem_ack, imem_rdata,
        output exec_done, exec_result, exec_wb_en,
        output exec_branch_taken, exec_branch_target, exec_illegal
    );
endinterface

// File: rtl/rv_core_sequencer.sv
// RV32I multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK, with a sticky TRAP state.
// Owns pc and instret; every output is registered.
module rv_core_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned EXEC_TIMEOUT = 16
) (
    input logic                  CLK,
    input logic                  RST,
    rv_core_sequencer_if.master  bus
);
    localparam int unsigned CW = $clog2(EXEC_TIMEOUT + 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP} state_t;

    state_t        r_state, w_state;
    logic [31:0]   r_pc, w_pc;
    logic [31:0]   r_instr, w_instr;
    logic [31:0]   r_instret, w_instret;
    logic          r_imem_req, w_imem_req;
    logic          r_exec_start, w_exec_start;
    logic [4:0]    r_rs1, w_rs1, r_rs2, w_rs2, r_rd, w_rd;
    logic          r_rf_we, w_rf_we;
    logic [31:0]   r_rf_wdata, w_rf_wdata;
    logic          r_halted, w_halted;
    logic [1:0]    r_cause, w_cause;
    logic          r_br_taken, w_br_taken;
    logic [31:0]   r_br_target, w_br_target;
    logic [CW-1:0] r_cnt, w_cnt;

    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_instr      = r_instr;
        w_instret    = r_instret;
        w_imem_req   = r_imem_req;
        w_exec_start = 1'b0;
        w_rs1        = r_rs1;
        w_rs2        = r_rs2;
        w_rd         = r_rd;
        w_rf_we      = 1'b0;
        w_rf_wdata   = r_rf_wdata;
        w_halted     = r_halted;
        w_cause      = r_cause;
        w_br_taken   = r_br_taken;
        w_br_target  = r_br_target;
        w_cnt        = r_cnt;
        case (r_state)
            S_FETCH: begin
                // req rises one cycle after reset; ack only counts once req is visible
                if (!r_imem_req) begin
                    w_imem_req = 1'b1;
                end else if (bus.imem_ack) begin
                    w_instr    = bus.imem_rdata;
                    w_imem_req = 1'b0;
                    w_state    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_rs1        = r_instr[19:15];
                w_rs2        = r_instr[24:20];
                w_rd         = r_instr[11:7];
                w_exec_start = 1'b1;
                w_cnt        = CW'(1);
                w_state      = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (bus.exec_done) begin
                    if (bus.exec_illegal) begin
                        w_halted = 1'b1;
                        w_cause  = 2'd1;
                        w_state  = S_TRAP;
                    end else begin
                        w_rf_wdata  = bus.exec_result;
                        w_br_taken  = bus.exec_branch_taken;
                        w_br_target = bus.exec_branch_target;
                        // write enable is resolved here so it is already registered in WRITEBACK
                        w_rf_we     = bus.exec_wb_en && (r_rd != 5'd0) &&
                                      !(bus.exec_branch_taken && (bus.exec_branch_target[1:0] != 2'b00));
                        w_state     = S_WRITEBACK;
                    end
                end else if (r_cnt == CW'(EXEC_TIMEOUT)) begin
                    w_halted = 1'b1;
                    w_cause  = 2'd3;
                    w_state  = S_TRAP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_WRITEBACK: begin
                if (r_br_taken && (r_br_target[1:0] != 2'b00)) begin
                    w_halted = 1'b1;
                    w_cause  = 2'd2;
                    w_state  = S_TRAP;
                end else begin
                    w_pc       = r_br_taken ? r_br_target : r_pc + 32'd4;
                    w_instret  = r_instret + 32'd1;
                    w_imem_req = 1'b1;
                    w_state    = S_FETCH;
                end
            end
            S_TRAP: begin
                w_state = S_TRAP;
            end
            default: begin
                w_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_instret    <= '0;
            r_imem_req   <= 1'b0;
            r_exec_start <= 1'b0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_rf_we      <= 1'b0;
            r_rf_wdata   <= '0;
            r_halted     <= 1'b0;
            r_cause      <= '0;
            r_br_taken   <= 1'b0;
            r_br_target  <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_instr      <= w_instr;
            r_instret    <= w_instret;
            r_imem_req   <= w_imem_req;
            r_exec_start <= w_exec_start;
            r_rs1        <= w_rs1;
            r_rs2        <= w_rs2;
            r_rd         <= w_rd;
            r_rf_we      <= w_rf_we;
            r_rf_wdata   <= w_rf_wdata;
            r_halted     <= w_halted;
            r_cause      <= w_cause;
            r_br_taken   <= w_br_taken;
            r_br_target  <= w_br_target;
            r_cnt        <= w_cnt;
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.pc          = r_pc;
    assign bus.rf_rs1_addr = r_rs1;
    assign bus.rf_rs2_addr = r_rs2;
    assign bus.rf_rd_addr  = r_rd;
    assign bus.rf_we       = r_rf_we;
    assign bus.rf_wdata    = r_rf_wdata;
    assign bus.exec_start  = r_exec_start;
    assign bus.instret     = r_instret;
    assign bus.halted      = r_halted;
    assign bus.trap_cause  = r_cause;
endmodule

// File: tb/tb_rv_core_sequencer.sv
// Bench for rv_core_sequencer: acts as memory and exec unit, predicts each instruction's
// outcome (retire, rf write, trap cause, next pc) from its handshake timing and result fields.
module tb_rv_core_sequencer;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0200;
    localparam int unsigned TB_TIMEOUT  = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    rv_core_sequencer_if bus();

    rv_core_sequencer #(.RESET_PC(TB_RESET_PC), .EXEC_TIMEOUT(TB_TIMEOUT)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic idle_inputs;
        bus.imem_ack           = 1'b0;
        bus.imem_rdata         = '0;
        bus.exec_done          = 1'b0;
        bus.exec_result        = '0;
        bus.exec_wb_en         = 1'b0;
        bus.exec_branch_taken  = 1'b0;
        bus.exec_branch_target = '0;
        bus.exec_illegal       = 1'b0;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("rst_pc",      bus.pc, TB_RESET_PC);
        chk("rst_instr",   bus.instr, 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        chk("rst_req",     32'(bus.imem_req), 32'd0);
        chk("rst_start",   32'(bus.exec_start), 32'd0);
        chk("rst_we",      32'(bus.rf_we), 32'd0);
        chk("rst_wdata",   bus.rf_wdata, 32'd0);
        chk("rst_addrs",   32'({bus.rf_rs1_addr, bus.rf_rs2_addr, bus.rf_rd_addr}), 32'd0);
        chk("rst_halted",  32'(bus.halted), 32'd0);
        chk("rst_cause",   32'(bus.trap_cause), 32'd0);
        RST = 1'b0;
        m_pc      = TB_RESET_PC;
        m_instret = 32'd0;
        tick();
        chk("first_req",  32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, TB_RESET_PC);
    endtask

    task automatic check_trap(input logic [1:0] cause);
        chk("trap_halted",  32'(bus.halted), 32'd1);
        chk("trap_cause",   32'(bus.trap_cause), 32'(cause));
        chk("trap_pc",      bus.pc, m_pc);
        chk("trap_instret", bus.instret, m_instret);
        chk("trap_we",      32'(bus.rf_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack  = 1'($urandom);
            bus.exec_done = 1'($urandom);
            tick();
            chk("trap_stay_halted", 32'(bus.halted), 32'd1);
            chk("trap_stay_req",    32'({bus.imem_req, bus.exec_start, bus.rf_we}), 32'd0);
            chk("trap_stay_pc",     bus.pc, m_pc);
        end
        idle_inputs();
    endtask

    // One instruction: ack after ack_dly idle cycles, done after done_dly idle EXECUTE cycles.
    task automatic do_instr(input int ack_dly, input int done_dly, input logic wb_en,
                            input logic [31:0] result, input logic [4:0] rd, input logic taken,
                            input logic [31:0] target, input logic illegal, input logic abort);
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] word;
        int          ticks;
        int          n_exec;
        bit          accepted;
        bit          misal;
        logic        exp_we;
        rs1      = 5'($urandom);
        rs2      = 5'($urandom);
        word     = {7'($urandom), rs2, rs1, 3'($urandom), rd, 7'($urandom)};
        ticks    = 0;
        accepted = (done_dly + 1 <= int'(TB_TIMEOUT));
        n_exec   = accepted ? done_dly + 1 : int'(TB_TIMEOUT);

        for (int w = 0; w < 4 && bus.imem_req !== 1'b1; w++) tick();
        chk("fetch_req",  32'(bus.imem_req), 32'd1);
        chk("fetch_addr", bus.imem_addr, m_pc);
        for (int i = 0; i < ack_dly; i++) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            tick();
            ticks++;
            chk("req_hold",  32'(bus.imem_req), 32'd1);
            chk("addr_hold", bus.imem_addr, m_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        ticks++;
        idle_inputs();
        chk("decode_req_low", 32'(bus.imem_req), 32'd0);
        chk("instr_latch",    bus.instr, word);
        tick();
        ticks++;
        chk("exec_start", 32'(bus.exec_start), 32'd1);
        chk("rf_addrs", 32'({bus.rf_rs1_addr, bus.rf_rs2_addr, bus.rf_rd_addr}), 32'({rs1, rs2, rd}));

        for (int k = 1; k <= n_exec; k++) begin
            if (abort && k == 2) begin
                RST = 1'b1;
                tick();
                chk("abort_we",    32'(bus.rf_we), 32'd0);
                chk("abort_pc",    bus.pc, TB_RESET_PC);
                chk("abort_start", 32'(bus.exec_start), 32'd0);
                return;
            end
            if (accepted && k == n_exec) begin
                bus.exec_done          = 1'b1;
                bus.exec_result        = result;
                bus.exec_wb_en         = wb_en;
                bus.exec_branch_taken  = taken;
                bus.exec_branch_target = target;
                bus.exec_illegal       = illegal;
            end else begin
                bus.exec_done    = 1'b0;
                bus.exec_illegal = 1'($urandom);
                bus.imem_ack     = 1'($urandom);
                bus.exec_result  = $urandom;
            end
            tick();
            ticks++;
            idle_inputs();
            if (k < n_exec) begin
                chk("start_once",  32'(bus.exec_start), 32'd0);
                chk("exec_halted", 32'(bus.halted), 32'd0);
            end
        end

        if (!accepted) begin
            check_trap(2'd3);
            return;
        end
        if (illegal) begin
            check_trap(2'd1);
            return;
        end
        misal  = taken && (target[1:0] != 2'b00);
        exp_we = wb_en && (rd != 5'd0) && !misal;
        chk("wb_we", 32'(bus.rf_we), 32'(exp_we));
        if (exp_we) chk("wb_wdata", bus.rf_wdata, result);
        tick();
        ticks++;
        chk("we_pulse_end", 32'(bus.rf_we), 32'd0);
        if (misal) begin
            check_trap(2'd2);
            return;
        end
        m_pc      = taken ? target : m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        chk("retire_pc",      bus.pc, m_pc);
        chk("retire_instret", bus.instret, m_instret);
        chk("retire_req",     32'(bus.imem_req), 32'd1);
        chk("latency",        32'(ticks), 32'(ack_dly + n_exec + 3));
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // steady state: immediate ack and done, rd=5, result 0x11
        for (int i = 0; i < 3; i++) do_instr(0, 0, 1'b1, 32'h11, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
        do_instr(3, 0, 1'b1, 32'hCAFE_0001, 5'd7, 1'b0, 32'd0, 1'b0, 1'b0);
        do_instr(0, 2, 1'b1, 32'h1234_5678, 5'd8, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        do_instr(1, 0, 1'b1, 32'h0BAD_F00D, 5'd9, 1'b0, 32'd0, 1'b0, 1'b0);
        do_instr(0, 0, 1'b1, 32'h5555_AAAA, 5'd3, 1'b1, 32'h0000_0102, 1'b0, 1'b0);
        do_reset();

        do_instr(0, 1000, 1'b1, 32'h1, 5'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        do_reset();
        do_instr(0, 15, 1'b1, 32'hFEED_BEEF, 5'd31, 1'b0, 32'd0, 1'b0, 1'b0);

        do_instr(0, 0, 1'b1, 32'h77, 5'd4, 1'b0, 32'd0, 1'b1, 1'b0);
        do_reset();

        do_instr(0, 0, 1'b1, 32'h99, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        do_instr(2, 1, 1'b0, 32'h42, 5'd12, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        do_instr(0, 0, 1'b1, 32'h43, 5'd13, 1'b0, 32'd0, 1'b0, 1'b0);

        do_instr(1, 1000, 1'b1, 32'h66, 5'd6, 1'b0, 32'd0, 1'b0, 1'b1);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            logic [4:0]  r_rd_sel;
            logic [31:0] tgt;
            r_rd_sel = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            tgt      = {30'($urandom), 2'b00};
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'($urandom),
                     $urandom, r_rd_sel, ($urandom_range(0, 3) == 0), tgt, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
